button_ctrl: RTL and testbench
==============================

# button_ctrl

Multi-channel push-button front end for the board's user buttons. It synchronises raw button pins and applies tick-paced debouncing from one shared sample prescaler. It then runs a per-channel press/hold/auto-repeat state machine and emits single-cycle press, release and repeat strobes. It sits between the board pins and the application control logic, such as stopwatch or clock FSMs, so that no downstream block samples a raw button.

## Interface
- N_BTN, 4, number of button channels
- TICK_DIV, 50000, clk cycles per debounce sample tick (≥2)
- STABLE_CNT, 4, consecutive equal samples needed to change a debounced level (≥2)
- HOLD_TICKS, 500, ticks a button must stay pressed before the first repeat strobe (≥1)
- REPEAT_TICKS, 100, ticks between subsequent repeat strobes (≥1)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset; synchronous, active-low
- btn_in  input  N_BTN  raw asynchronous button pins, active-high
- btn_level  output  N_BTN  debounced level per channel
- btn_press  output  N_BTN  one-clk strobe on debounced 0→1
- btn_release  output  N_BTN  one-clk strobe on debounced 1→0
- btn_repeat  output  N_BTN  one-clk strobe on hold/auto-repeat
- sample_tick  output  1  shared prescaler tick, exposed for test

## Operation
- Synchroniser: each btn_in bit passes through 2 flops, which reset to 0. Only the second-stage value (sync) is used downstream.
- Prescaler: a single counter of width $clog2(TICK_DIV) counts 0..TICK_DIV-1 and wraps to 0.
  - sample_tick=1 combinationally while counter==TICK_DIV-1, so it is high exactly one clk per TICK_DIV.
- Debounce, per channel: a STABLE_CNT-bit shift register shifts in sync only on cycles with sample_tick=1.
  - The comparison uses the post-shift contents, i.e. {shreg[STABLE_CNT-2:0], sync}.
  - All ones with level=0: level←1 and press←1.
  - All zeros with level=1: level←0 and release←1.
  - Mixed pattern: level holds. This gives hysteresis, so glitches shorter than STABLE_CNT ticks never toggle the level.
- Hold FSM, per channel. The states are IDLE, PRESSED and REPEAT, with a tick counter cnt of width $clog2(max(HOLD_TICKS,REPEAT_TICKS)+1).
  - IDLE: when the press condition is met, go to PRESSED with cnt←0.
  - PRESSED: on each tick, cnt←cnt+1. On the tick where cnt==HOLD_TICKS-1, repeat←1, go to REPEAT and set cnt←0.
  - REPEAT: on each tick, cnt←cnt+1. On the tick where cnt==REPEAT_TICKS-1, repeat←1 and cnt←0.
  - PRESSED or REPEAT: when the release condition is met, go to IDLE with cnt←0.
- Release has priority. If release and repeat are due on the same tick, only the release strobe fires and the FSM goes to IDLE.
- Channels are fully independent. Simultaneous events on different channels all fire in the same cycle. There is no serialisation.

## Timing
- Reset (rst_n=0 at a rising edge) clears:
  - the synchronisers, prescaler, shift registers and cnt (all to 0);
  - the FSMs (to IDLE);
  - btn_level, btn_press, btn_release and btn_repeat (all to 0), and sample_tick (0).
- Reset mid-press drops btn_level to 0 without a release strobe. Any strobe pending that edge is lost.
- All strobes are registered, set on the tick edge and cleared on the next edge, so each is high exactly 1 clk.
- btn_press is high in the first cycle in which btn_level=1. btn_release is high in the first cycle in which btn_level=0.
- Press latency from a clean, stable btn_in rise is 2 clk (synchroniser) plus STABLE_CNT ticks, capped at 2+STABLE_CNT·TICK_DIV+1 clk.
- First btn_repeat comes HOLD_TICKS ticks after the btn_press edge. Subsequent repeats come every REPEAT_TICKS ticks.
- Counters never overflow. Every counter wraps explicitly at its terminal value.

## Test plan
Parameters for all cases: TICK_DIV=4, STABLE_CNT=3, HOLD_TICKS=5, REPEAT_TICKS=2, N_BTN=4.

- Reset and prescaler: hold rst_n=0 for 5 clk, then release. All outputs are 0 during reset. sample_tick then pulses on cycles 3, 7, 11… after release, 1 clk wide each.
- Clean press/release on btn_in[0]: raise it, hold 40 clk, then drop it.
  - One btn_press[0] pulse arrives ≤15 clk after the rise, and btn_level[0] goes to 1.
  - One btn_release[0] pulse arrives ≤15 clk after the fall.
  - No other channel toggles.
- Bounce rejection: toggle btn_in[1] every 5 clk for 60 clk, with fewer than 3 consecutive equal tick samples. btn_level[1] stays 0 and btn_press[1] never fires.
- Hold/repeat: hold btn_in[2] high.
  - btn_repeat[2] fires 5 ticks (20 clk) after btn_press[2], then every 2 ticks (8 clk).
  - After release, btn_repeat[2] stops and btn_release[2] fires once.
- Release/repeat collision: release btn_in[2] so the release condition lands on a tick where a repeat is due. Only btn_release[2] fires and the FSM returns to IDLE.
- Reset mid-operation: assert rst_n=0 while btn_level[3]=1 and REPEAT is active. Outputs are 0 the next cycle with no release strobe. After rst_n=1 with btn_in[3] still high, a fresh btn_press[3] fires within 15 clk.

Source files
------------

// File: rtl/button_ctrl.sv
// Push-button front end: 2-flop synchroniser, shared debounce tick prescaler,
// per-channel hysteresis debounce and press/hold/auto-repeat strobe generation.
module button_ctrl #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_CNT   = 4,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             sample_tick
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int HW   = STABLE_CNT - 1;
  localparam int CMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [PW-1:0]         PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]         HOLD_LAST  = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0]         RPT_LAST   = CW'(REPEAT_TICKS - 1);
  localparam logic [STABLE_CNT-1:0] ALL_ONES   = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_REPEAT} hold_state_t;

  logic [N_BTN-1:0]                 sync1_q, sync1_d;
  logic [N_BTN-1:0]                 sync2_q, sync2_d;
  logic [PW-1:0]                    presc_q, presc_d;
  logic [N_BTN-1:0][HW-1:0]         hist_q, hist_d;
  logic [N_BTN-1:0][STABLE_CNT-1:0] window;
  hold_state_t [N_BTN-1:0]          state_q, state_d;
  logic [N_BTN-1:0][CW-1:0]         cnt_q, cnt_d;
  logic [N_BTN-1:0]                 level_q, level_d;
  logic [N_BTN-1:0]                 press_q, press_d;
  logic [N_BTN-1:0]                 release_q, release_d;
  logic [N_BTN-1:0]                 repeat_q, repeat_d;
  logic [N_BTN-1:0]                 rise, fall;

  assign sample_tick = (presc_q == PRESC_LAST);

  always_comb begin
    sync1_d   = btn_in;
    sync2_d   = sync1_q;
    presc_d   = sample_tick ? '0 : presc_q + PW'(1);
    hist_d    = hist_q;
    window    = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    rise      = '0;
    fall      = '0;
    for (int i = 0; i < N_BTN; i++) begin
      // The oldest sample would be shifted out before the next decision, so
      // only STABLE_CNT-1 history bits are stored; the window adds sync.
      window[i] = {hist_q[i], sync2_q[i]};
      if (sample_tick) begin
        hist_d[i] = window[i][HW-1:0];
        rise[i]   = (window[i] == ALL_ONES) && !level_q[i];
        fall[i]   = (window[i] == '0) && level_q[i];
        if (rise[i]) begin
          level_d[i] = 1'b1;
          press_d[i] = 1'b1;
        end
        if (fall[i]) begin
          level_d[i]   = 1'b0;
          release_d[i] = 1'b1;
        end
        case (state_q[i])
          ST_IDLE: begin
            if (rise[i]) begin
              state_d[i] = ST_PRESSED;
              cnt_d[i]   = '0;
            end
          end
          ST_PRESSED: begin
            if (fall[i]) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == HOLD_LAST) begin
              repeat_d[i] = 1'b1;
              state_d[i]  = ST_REPEAT;
              cnt_d[i]    = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          ST_REPEAT: begin
            if (fall[i]) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == RPT_LAST) begin
              repeat_d[i] = 1'b1;
              cnt_d[i]    = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      presc_q   <= '0;
      hist_q    <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < N_BTN; i++) state_q[i] <= ST_IDLE;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      presc_q   <= presc_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      state_q   <= state_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Directed + random bench for button_ctrl, checked every cycle against a
// run-length / held-tick reference model.
module tb_button_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SC = 3;
  localparam int HT = 5;
  localparam int RT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic         sample_tick;

  button_ctrl #(
    .N_BTN(N), .TICK_DIV(TD), .STABLE_CNT(SC), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: edges since reset, pipeline-delayed pin, run of equal
  // tick samples, and ticks elapsed since the press tick.
  int           n_m;
  logic [N-1:0] sync1_m, sync2_m, level_m, press_m, rel_m, rep_m;
  logic         run_val [N];
  int           run_len [N];
  int           held_m  [N];
  bit           tick_edge_m;
  int           press_cnt [N];
  int           rel_cnt   [N];
  int           rep_cnt   [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    n_m = 0;
    sync1_m = '0; sync2_m = '0; level_m = '0;
    press_m = '0; rel_m = '0; rep_m = '0;
    tick_edge_m = 0;
    for (int c = 0; c < N; c++) begin
      run_val[c] = 1'b0;
      run_len[c] = SC;
      held_m[c]  = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      tick_edge_m = ((n_m % TD) == TD - 1);
      press_m = '0; rel_m = '0; rep_m = '0;
      if (tick_edge_m) begin
        for (int c = 0; c < N; c++) begin
          if (sync2_m[c] == run_val[c]) run_len[c]++;
          else begin
            run_val[c] = sync2_m[c];
            run_len[c] = 1;
          end
          if (run_len[c] >= SC && run_val[c] != level_m[c]) begin
            level_m[c] = run_val[c];
            if (run_val[c]) begin
              press_m[c] = 1'b1;
              held_m[c]  = 0;
            end else begin
              rel_m[c] = 1'b1;
            end
          end else if (level_m[c]) begin
            held_m[c]++;
            if (held_m[c] >= HT && ((held_m[c] - HT) % RT) == 0) rep_m[c] = 1'b1;
          end
        end
      end
      sync2_m = sync1_m;
      sync1_m = btn_in;
      n_m++;
    end
    #1;
    cyc++;
    chk("btn_level",   32'(btn_level),   32'(level_m));
    chk("btn_press",   32'(btn_press),   32'(press_m));
    chk("btn_release", 32'(btn_release), 32'(rel_m));
    chk("btn_repeat",  32'(btn_repeat),  32'(rep_m));
    chk("sample_tick", 32'(sample_tick), 32'((n_m % TD) == TD - 1));
    for (int c = 0; c < N; c++) begin
      press_cnt[c] += int'(btn_press[c]);
      rel_cnt[c]   += int'(btn_release[c]);
      rep_cnt[c]   += int'(btn_repeat[c]);
    end
  endtask

  initial begin
    int first;
    int press_at;
    int rep_q[$];
    int rep_before;
    bit found;

    for (int c = 0; c < N; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; rep_cnt[c] = 0;
    end
    rst_n  = 1'b0;
    btn_in = '0;
    model_reset();

    // Reset held for 5 clk: every output must read 0.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_outputs", 32'({btn_level, btn_press, btn_release, btn_repeat, sample_tick}), 32'd0);
    end
    rst_n = 1'b1;

    // Prescaler phase right after reset release.
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("tick_phase", 32'(sample_tick), 32'((c % 4) == 3));
    end

    // Clean press / release on channel 0.
    btn_in[0] = 1'b1;
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (btn_press[0] && first < 0) first = i;
    end
    chk("press0_within_15", 32'(first >= 1 && first <= 15), 32'd1);
    chk("press0_count", 32'(press_cnt[0]), 32'd1);
    chk("level0_high", 32'(btn_level[0]), 32'd1);
    btn_in[0] = 1'b0;
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (btn_release[0] && first < 0) first = i;
    end
    chk("release0_within_15", 32'(first >= 1 && first <= 15), 32'd1);
    chk("release0_count", 32'(rel_cnt[0]), 32'd1);
    chk("others_quiet", 32'(press_cnt[1] + press_cnt[2] + press_cnt[3] +
                            rel_cnt[1] + rel_cnt[2] + rel_cnt[3]), 32'd0);

    // Bounce on channel 1: toggling every 5 clk never yields 3 equal ticks.
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) btn_in[1] = ~btn_in[1];
      step();
    end
    btn_in[1] = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("bounce1_no_press", 32'(press_cnt[1]), 32'd0);
    chk("bounce1_level_low", 32'(btn_level[1]), 32'd0);

    // Hold / auto-repeat on channel 2.
    btn_in[2] = 1'b1;
    press_at = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (btn_press[2]) begin
        press_at = cyc;
        break;
      end
    end
    chk("press2_seen", 32'(press_at >= 0), 32'd1);
    for (int i = 0; i < 40; i++) begin
      step();
      if (btn_repeat[2]) rep_q.push_back(cyc);
    end
    chk("rep2_count", 32'(rep_q.size() >= 3), 32'd1);
    if (rep_q.size() >= 3) begin
      chk("rep2_first_gap", 32'(rep_q[0] - press_at), 32'd20);
      chk("rep2_period_a", 32'(rep_q[1] - rep_q[0]), 32'd8);
      chk("rep2_period_b", 32'(rep_q[2] - rep_q[1]), 32'd8);
    end

    // Drop the pin so the third zero sample lands on a repeat-due tick.
    found = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tick_edge_m && level_m[2] && held_m[2] >= 6 && (held_m[2] % 2) == 0) begin
        found = 1;
        break;
      end
    end
    chk("collide_setup", 32'(found), 32'd1);
    btn_in[2] = 1'b0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (btn_release[2]) begin
        found = 1;
        chk("collide_no_repeat", 32'(btn_repeat[2]), 32'd0);
      end
    end
    chk("collide_release_seen", 32'(found), 32'd1);
    chk("rel2_count", 32'(rel_cnt[2]), 32'd1);
    rep_before = rep_cnt[2];
    for (int i = 0; i < 20; i++) step();
    chk("rep2_stopped", 32'(rep_cnt[2]), 32'(rep_before));

    // Reset mid-operation on channel 3 while auto-repeating.
    btn_in[3] = 1'b1;
    found = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (rep_cnt[3] >= 1) begin
        found = 1;
        break;
      end
    end
    chk("rep3_active", 32'(found), 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_level3", 32'(btn_level[3]), 32'd0);
    chk("midrst_no_release", 32'(btn_release), 32'd0);
    rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (btn_press[3]) begin
        first = i;
        break;
      end
    end
    chk("repress3_within_15", 32'(first >= 1), 32'd1);

    // Random pin activity across all channels.
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 11) == 0) btn_in[c] = ~btn_in[c];
      step();
    end
    btn_in = '0;
    for (int i = 0; i < 30; i++) step();
    chk("final_levels_low", 32'(btn_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
